// File: rtl/timer_mc_pkg.sv
// Shared register map, CTRL bit layout and byte-enable helper for the
// multi-channel timer.
package timer_mc_pkg;

    localparam logic [3:0] OFF_CTRL = 4'h0;
    localparam logic [3:0] OFF_PRE  = 4'h4;
    localparam logic [3:0] OFF_ARE  = 4'h8;
    localparam logic [3:0] OFF_CNT  = 4'hC;

    localparam int CTRL_ENA     = 0;
    localparam int CTRL_DIR     = 1;
    localparam int CTRL_ONESHOT = 2;
    localparam int CTRL_CLR     = 3;
    localparam int CTRL_EVC     = 4;

    localparam int EVN_W = 16;

    function automatic int irq_stat_off(input int n_ch);
        return n_ch * 16;
    endfunction

    function automatic int irq_en_off(input int n_ch);
        return n_ch * 16 + 4;
    endfunction

    // Replace only the bytes whose enable is set.
    function automatic logic [31:0] be_merge(input logic [31:0] old,
                                             input logic [31:0] wd,
                                             input logic [3:0]  be);
        logic [31:0] res;
        for (int i = 0; i < 4; i++)
            res[i*8 +: 8] = be[i] ? wd[i*8 +: 8] : old[i*8 +: 8];
        return res;
    endfunction

endpackage

// File: rtl/timer_mc_ch.sv
// One timer channel: prescaler, auto-reload up/down counter, one-shot
// handling and saturating event counter.
module timer_mc_ch
    import timer_mc_pkg::*;
#(
    parameter int CNT_W   = 32,
    parameter int PRE_RST = 59_999_999
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [3:0]       be,
    input  logic [31:0]      wdata,
    input  logic             ctrl_we,
    input  logic             pre_we,
    input  logic             are_we,
    input  logic             cnt_we,
    output logic [31:0]      ctrl,
    output logic [CNT_W-1:0] pre,
    output logic [CNT_W-1:0] are,
    output logic [CNT_W-1:0] cnt,
    output logic             evt
);

    logic             ena, dir, oneshot;
    logic [CNT_W-1:0] pcnt;
    logic [EVN_W-1:0] evn;
    logic             clr, evc, tick, wrap;

    assign clr  = ctrl_we && be[0] && wdata[CTRL_CLR];
    assign evc  = ctrl_we && be[0] && wdata[CTRL_EVC];
    assign tick = ena && (pcnt == pre);
    assign wrap = dir ? (cnt == are) : (cnt == '0);
    // A CLR or CNT write overrides the tick update, so no event either.
    assign evt  = tick && wrap && !clr && !cnt_we;

    assign ctrl = {evn, 11'b0, 2'b0, oneshot, dir, ena};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ena     <= 1'b0;
            dir     <= 1'b0;
            oneshot <= 1'b0;
        end else begin
            if (ctrl_we && be[0]) begin
                ena     <= wdata[CTRL_ENA];
                dir     <= wdata[CTRL_DIR];
                oneshot <= wdata[CTRL_ONESHOT];
            end
            if (evt && oneshot)
                ena <= 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pre <= CNT_W'(PRE_RST);
            are <= '0;
        end else begin
            if (pre_we)
                pre <= CNT_W'(be_merge(32'(pre), wdata, be));
            if (are_we)
                are <= CNT_W'(be_merge(32'(are), wdata, be));
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            pcnt <= '0;
        else if (clr || pre_we)
            pcnt <= '0;
        else if (ena)
            pcnt <= tick ? '0 : pcnt + CNT_W'(1);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            cnt <= '0;
        else if (clr)
            cnt <= '0;
        else if (cnt_we)
            cnt <= CNT_W'(be_merge(32'(cnt), wdata, be));
        else if (tick) begin
            if (dir)
                cnt <= wrap ? '0 : cnt + CNT_W'(1);
            else
                cnt <= wrap ? are : cnt - CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            evn <= '0;
        else if (evc)
            evn <= '0;
        else if (evt && evn != '1)
            evn <= evn + EVN_W'(1);
    end

endmodule

// File: rtl/timer_mc.sv
// Multi-channel peripheral timer: bus decode, read mux and the shared
// maskable interrupt with W1C status and id-checked acknowledge.
module timer_mc
    import timer_mc_pkg::*;
#(
    parameter int N_CH    = 4,
    parameter int CNT_W   = 32,
    parameter int IRQ_ID  = 7,
    parameter int PRE_RST = 59_999_999,
    localparam int ADDR_W = $clog2(N_CH*16+8)
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              write_i,
    input  logic [3:0]        data_be_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [31:0]       wdata_i,
    output logic [31:0]       rdata_o,
    output logic              irq_o,
    input  logic              irq_ack_i,
    input  logic [4:0]        irq_id_i
);

    localparam int CH_W = ADDR_W - 4;
    localparam logic [ADDR_W-1:0] STAT_A = ADDR_W'(irq_stat_off(N_CH));
    localparam logic [ADDR_W-1:0] EN_A   = ADDR_W'(irq_en_off(N_CH));

    logic                        sel_ch, stat_hit, en_hit, ack;
    logic [CH_W-1:0]             ch_idx;
    logic [3:0]                  off;
    logic [N_CH-1:0][31:0]       ch_ctrl, ch_rd;
    logic [N_CH-1:0][CNT_W-1:0]  ch_pre, ch_are, ch_cnt;
    logic [N_CH-1:0]             ch_evt, irq_stat, irq_en, stat_w1c;

    assign sel_ch   = addr_i < STAT_A;
    assign ch_idx   = addr_i[ADDR_W-1:4];
    assign off      = addr_i[3:0];
    assign stat_hit = addr_i[ADDR_W-1:2] == STAT_A[ADDR_W-1:2];
    assign en_hit   = addr_i[ADDR_W-1:2] == EN_A[ADDR_W-1:2];

    for (genvar g = 0; g < N_CH; g++) begin : g_ch
        logic hit;
        assign hit = sel_ch && (ch_idx == CH_W'(g));

        timer_mc_ch #(.CNT_W(CNT_W), .PRE_RST(PRE_RST)) u_ch (
            .clk     (clk_i),
            .rst     (rst_i),
            .be      (data_be_i),
            .wdata   (wdata_i),
            .ctrl_we (write_i && hit && off == OFF_CTRL),
            .pre_we  (write_i && hit && off == OFF_PRE),
            .are_we  (write_i && hit && off == OFF_ARE),
            .cnt_we  (write_i && hit && off == OFF_CNT),
            .ctrl    (ch_ctrl[g]),
            .pre     (ch_pre[g]),
            .are     (ch_are[g]),
            .cnt     (ch_cnt[g]),
            .evt     (ch_evt[g])
        );

        assign ch_rd[g] = !hit             ? 32'b0 :
                          off == OFF_CTRL  ? ch_ctrl[g] :
                          off == OFF_PRE   ? 32'(ch_pre[g]) :
                          off == OFF_ARE   ? 32'(ch_are[g]) :
                                             32'(ch_cnt[g]);
    end

    assign ack      = irq_ack_i && (irq_id_i == 5'(IRQ_ID));
    assign stat_w1c = (write_i && stat_hit && data_be_i[0]) ? wdata_i[N_CH-1:0] : '0;

    // New events are OR-ed in last so they survive a same-cycle W1C or ack.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            irq_stat <= '0;
            irq_en   <= '0;
        end else begin
            irq_stat <= (ack ? '0 : (irq_stat & ~stat_w1c)) | ch_evt;
            if (write_i && en_hit && data_be_i[0])
                irq_en <= wdata_i[N_CH-1:0];
        end
    end

    assign irq_o = |(irq_stat & irq_en);

    always_comb begin
        rdata_o = '0;
        for (int c = 0; c < N_CH; c++)
            rdata_o |= ch_rd[c];
        if (stat_hit)
            rdata_o = 32'(irq_stat);
        if (en_hit)
            rdata_o = 32'(irq_en);
    end

endmodule

// File: tb/tb_timer_mc.sv
// Directed bench for timer_mc with default parameters (4 channels, 32-bit).
module tb_timer_mc;

    logic        clk, rst, write, irq, irq_ack;
    logic [3:0]  data_be;
    logic [6:0]  addr;
    logic [31:0] wdata, rdata;
    logic [4:0]  irq_id;
    int          n_cmp = 0;
    int          n_bad = 0;

    timer_mc dut (
        .clk_i     (clk),
        .rst_i     (rst),
        .write_i   (write),
        .data_be_i (data_be),
        .addr_i    (addr),
        .wdata_i   (wdata),
        .rdata_o   (rdata),
        .irq_o     (irq),
        .irq_ack_i (irq_ack),
        .irq_id_i  (irq_id)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic rdchk(input logic [6:0] a, input logic [31:0] exp, input string tag);
        addr  = a;
        write = 1'b0;
        #1;
        chk(tag, rdata, exp);
    endtask

    task automatic wr(input logic [6:0] a, input logic [31:0] d, input logic [3:0] be);
        addr    = a;
        wdata   = d;
        data_be = be;
        write   = 1'b1;
        @(posedge clk);
        #1;
        write   = 1'b0;
        data_be = 4'h0;
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_ack(input logic [4:0] id);
        irq_ack = 1'b1;
        irq_id  = id;
        step(1);
        irq_ack = 1'b0;
    endtask

    initial begin
        rst = 1'b1; write = 1'b0; data_be = 4'h0; addr = '0; wdata = '0;
        irq_ack = 1'b0; irq_id = '0;
        #12 rst = 1'b0;

        // reset state
        rdchk(7'h04, 32'd59_999_999, "rst_pre");
        rdchk(7'h0C, 32'h0, "rst_cnt");
        rdchk(7'h00, 32'h0, "rst_ctrl");
        rdchk(7'h40, 32'h0, "rst_stat");
        chk("rst_irq", {31'b0, irq}, 32'h0);

        // ch0 up, PRE=0, ARE=3
        wr(7'h04, 32'd0, 4'hF);
        wr(7'h08, 32'd3, 4'hF);
        wr(7'h44, 32'h1, 4'hF);
        wr(7'h00, 32'h3, 4'hF);
        rdchk(7'h0C, 32'd0, "c0_cnt0");
        step(1); rdchk(7'h0C, 32'd1, "c0_cnt1");
        step(1); rdchk(7'h0C, 32'd2, "c0_cnt2");
        step(1); rdchk(7'h0C, 32'd3, "c0_cnt3");
        chk("c0_irq_pre", {31'b0, irq}, 32'h0);
        step(1); rdchk(7'h0C, 32'd0, "c0_wrap");
        chk("c0_irq", {31'b0, irq}, 32'h1);
        rdchk(7'h40, 32'h1, "c0_stat");
        rdchk(7'h00, 32'h0001_0003, "c0_ctrl_evn");
        wr(7'h00, 32'h0, 4'hF);
        wr(7'h40, 32'h1, 4'hF);
        chk("c0_w1c_irq", {31'b0, irq}, 32'h0);

        // ch1 down, PRE=2, ARE=5, start at 2
        wr(7'h14, 32'd2, 4'hF);
        wr(7'h18, 32'd5, 4'hF);
        wr(7'h1C, 32'd2, 4'hF);
        wr(7'h44, 32'h2, 4'hF);
        wr(7'h10, 32'h1, 4'hF);
        rdchk(7'h1C, 32'd2, "c1_cnt_load");
        step(2); rdchk(7'h1C, 32'd2, "c1_hold");
        step(1); rdchk(7'h1C, 32'd1, "c1_cnt1");
        step(3); rdchk(7'h1C, 32'd0, "c1_cnt0");
        chk("c1_irq_pre", {31'b0, irq}, 32'h0);
        step(3); rdchk(7'h1C, 32'd5, "c1_reload");
        chk("c1_irq", {31'b0, irq}, 32'h1);
        rdchk(7'h10, 32'h0001_0001, "c1_ctrl_evn");
        wr(7'h10, 32'h0, 4'hF);
        do_ack(5'd6);
        chk("c1_ack_wrong_id", {31'b0, irq}, 32'h1);
        do_ack(5'd7);
        chk("c1_ack_ok", {31'b0, irq}, 32'h0);
        rdchk(7'h40, 32'h0, "c1_stat_acked");

        // ch2 one-shot up, ARE=1
        wr(7'h24, 32'd0, 4'hF);
        wr(7'h28, 32'd1, 4'hF);
        wr(7'h44, 32'h4, 4'hF);
        wr(7'h20, 32'h7, 4'hF);
        step(1); rdchk(7'h2C, 32'd1, "c2_cnt1");
        step(1); rdchk(7'h20, 32'h0001_0006, "c2_ena_cleared");
        rdchk(7'h2C, 32'd0, "c2_cnt0");
        chk("c2_irq", {31'b0, irq}, 32'h1);
        step(3); rdchk(7'h2C, 32'd0, "c2_cnt_held");
        rdchk(7'h20, 32'h0001_0006, "c2_one_event");

        // event vs W1C and vs ack: ch0 ARE=0 fires every tick
        wr(7'h00, 32'h8, 4'hF);
        wr(7'h08, 32'd0, 4'hF);
        wr(7'h00, 32'h3, 4'hF);
        step(1);
        wr(7'h40, 32'h5, 4'hF);
        rdchk(7'h40, 32'h1, "evt_beats_w1c");
        do_ack(5'd7);
        rdchk(7'h40, 32'h1, "evt_beats_ack");
        wr(7'h00, 32'h0, 4'hF);
        wr(7'h40, 32'h1, 4'hF);
        rdchk(7'h40, 32'h0, "stat_cleared");

        // CLR coinciding with a tick on ch1 (up, PRE=2, ARE=5)
        wr(7'h14, 32'd2, 4'hF);
        wr(7'h18, 32'd5, 4'hF);
        wr(7'h10, 32'hA, 4'hF);
        rdchk(7'h1C, 32'd0, "clr_only");
        wr(7'h10, 32'h3, 4'hF);
        step(5); rdchk(7'h1C, 32'd1, "c1_up_tick");
        wr(7'h10, 32'hB, 4'hF);
        rdchk(7'h1C, 32'd0, "clr_vs_tick");
        step(2); rdchk(7'h1C, 32'd0, "clr_pcnt0");
        step(1); rdchk(7'h1C, 32'd1, "clr_next_tick");

        // byte enables and unmapped space
        wr(7'h38, 32'hFFFF_FFFF, 4'b0001);
        rdchk(7'h38, 32'h0000_00FF, "be_are");
        wr(7'h34, 32'h0, 4'b0100);
        rdchk(7'h34, 32'h0300_86FF, "be_pre");
        rdchk(7'h48, 32'h0, "unmapped_rd");
        wr(7'h4C, 32'hFF, 4'hF);
        rdchk(7'h44, 32'h4, "unmapped_wr");

        // async reset mid-count with irq asserted
        wr(7'h44, 32'h1, 4'hF);
        wr(7'h00, 32'h3, 4'hF);
        step(1);
        chk("pre_rst_irq", {31'b0, irq}, 32'h1);
        #2 rst = 1'b1;
        #1 chk("arst_irq", {31'b0, irq}, 32'h0);
        rdchk(7'h1C, 32'h0, "arst_cnt");
        rdchk(7'h34, 32'd59_999_999, "arst_pre");
        rdchk(7'h10, 32'h0, "arst_ctrl");
        rdchk(7'h44, 32'h0, "arst_en");
        rst = 1'b0;
        step(1);
        rdchk(7'h40, 32'h0, "arst_stat");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/timer_mc.md
# timer_mc

Multi-channel, parametrised successor to the single-channel peripheral timer. Provides `N_CH` independent channels, each with its own prescaler, auto-reload counter, up/down and one-shot modes, and saturating event counter. Sits on the peripheral bus (`write_i`/`data_be_i`/`addr_i`/`wdata_i`/`rdata_o`). Drives one shared, maskable interrupt line with per-channel status and the existing ack/id handshake.

## Interface
- `N_CH`, 4: channel count, 1..8.
- `CNT_W`, 32: counter/prescaler/reload width, 8..32. Narrower fields are zero-extended on read and truncated on write.
- `IRQ_ID`, 7: id that `irq_ack_i` must carry.
- `PRE_RST`, 59_999_999: reset value of every `PRE`.
- `ADDR_W`: localparam, `$clog2(N_CH*16+8)`.

Ports:
- `clk_i` in 1: single clock.
- `rst_i` in 1: asynchronous, active-high reset.
- `write_i` in 1: write strobe; a read otherwise.
- `data_be_i` in 4: byte enables.
- `addr_i` in `ADDR_W`: byte address, word aligned.
- `wdata_i` in 32: write data.
- `rdata_o` out 32: read data.
- `irq_o` out 1: interrupt, OR of enabled pending bits.
- `irq_ack_i` in 1: interrupt acknowledge.
- `irq_id_i` in 5: id of the acknowledged interrupt.

## Operation
- Channel c registers are at base `c*16`:
  - `CTRL` +0x0:
    - [0] `ENA`, RW.
    - [1] `DIR`, RW: 1 = up, 0 = down.
    - [2] `ONESHOT`, RW.
    - [3] `CLR`, write-1 strobe, reads 0.
    - [4] `EVC`, write-1 strobe, reads 0.
    - [31:16] `EVN`, RO, saturating event count.
  - `PRE` +0x4, RW.
  - `ARE` +0x8, RW.
  - `CNT` +0xC, RW.
- Global registers:
  - `IRQ_STAT` at `N_CH*16`: W1C, bit c is channel c.
  - `IRQ_EN` at `N_CH*16+4`: RW.
- Unmapped reads return 0. Unmapped writes are ignored.
- Byte enables gate every RW field and every strobe/W1C bit.
- Prescaler: internal `pcnt`. While `ENA`=1, each cycle either `pcnt` increments or, when `pcnt==PRE`, it issues a tick and clears to 0. `PRE`=N gives one tick every N+1 cycles. `ENA`=0 holds `pcnt`.
- On a tick in up mode:
  - If `CNT==ARE`: `CNT`←0 and an event fires.
  - Otherwise: `CNT`←`CNT`+1.
- On a tick in down mode:
  - If `CNT==0`: `CNT`←`ARE` and an event fires.
  - Otherwise: `CNT`←`CNT`-1.
- An event does all of the following:
  - Sets `IRQ_STAT[c]`.
  - Increments `EVN`, saturating at 0xFFFF.
  - If `ONESHOT`=1, clears `ENA` by hardware.
- `CLR` clears `CNT` and `pcnt`. `EVC` clears `EVN`.
- A write to `PRE` clears `pcnt`. A write to `CNT` loads it and leaves `pcnt` unchanged.
- Ack: `irq_ack_i && irq_id_i==IRQ_ID` clears all `IRQ_STAT` bits.
- `irq_o` = |(`IRQ_STAT` & `IRQ_EN`).
- Priority per channel, highest first:
  - `rst_i`
  - `CLR` / `CNT` write
  - tick update
- Status bits: a set from an event wins over a W1C or an ack in the same cycle.
- `EVN`: an `EVC` wins over an increment in the same cycle.
- A hardware `ENA` clear wins over a simultaneous software `ENA`=1 write.

## Timing
- Writes take effect at the next `clk_i` rising edge.
- `rdata_o` is combinational from `addr_i` and the registered state.
- A tick decided in cycle t updates `CNT`, `EVN` and `IRQ_STAT` at edge t+1.
- `irq_o` is combinational from the registered `IRQ_STAT`/`IRQ_EN`, so it rises in the cycle after the event edge and falls in the cycle after the ack edge.
- Reset (async assert, applies immediately, including mid-count):
  - `CTRL`, `ARE`, `CNT`, `pcnt`, `IRQ_STAT`, `IRQ_EN` = 0.
  - `PRE` = `PRE_RST`.
  - `irq_o` = 0, `rdata_o` = read of the reset state.
- Wrap-around: up mode never exceeds `ARE`. A software write with `CNT`>`ARE` counts up to 2^`CNT_W`−1, wraps to 0, then reaches `ARE`. Down mode from 0 reloads `ARE`.
- Up mode with `ARE`=0 fires every tick.

## Structure
- Package `timer_mc_pkg`:
  - register offsets
  - `CTRL` bit positions
  - `EVN` width (16)
  - `IRQ_STAT`/`IRQ_EN` offset helpers
- Sub-module `timer_mc_ch`: one channel, holding prescaler, counter, event/oneshot logic and `EVN`. It takes write-strobe inputs and exports `CTRL`/`PRE`/`ARE`/`CNT`/`event`.
- Top level: generate loop over `N_CH`, address decode, read mux, `IRQ_STAT`/`IRQ_EN`, ack logic.

## Test plan
- Ch0: `PRE`=0, `ARE`=3, up, `ENA`=1, `IRQ_EN`=1 → `CNT` goes 1,2,3,0. Event at the 4th tick, `IRQ_STAT`=1, `irq_o`=1 one cycle later, `EVN`=1.
- Ch1: `PRE`=2, `ARE`=5, down, start `CNT`=2 → ticks every 3 cycles: 1, 0, then 5 with an event. Ack with `irq_id_i`=7 clears `irq_o`. Ack with `irq_id_i`=6 leaves it set.
- Ch2 one-shot, up, `ARE`=1 → exactly one event, then `ENA` reads 0 and `CNT` holds 0.
- Event in the same cycle as a `IRQ_STAT` W1C and as an ack → status stays 1. `CLR` in the same cycle as a tick → `CNT`=0, `pcnt`=0.
- Byte-enable write `data_be_i`=0001 of 0xFFFFFFFF to `ARE` (reset 0) → `ARE`=0x000000FF.
- Assert `rst_i` mid-count, asynchronously between edges → all state is at reset values immediately, `irq_o`=0, and `PRE` reads 59_999_999.
